// File: rtl/spi_reg_access.sv
// Register-access sequencer for an ADXL345 behind a byte-level SPI master.
// Frames one host command (register write or 1..MAX_BURST byte read) into a single chip-select window.
module spi_reg_access #(
    parameter int MAX_BURST = 6,
    parameter int LEN_W     = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [5:0]       cmd_addr,
    input  logic [7:0]       cmd_wdata,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             rd_last,
    output logic             done,
    output logic             busy,
    output logic             spi_tx_request,
    output logic [7:0]       spi_tx_data,
    output logic             spi_rx_request,
    input  logic [7:0]       spi_rx_data,
    input  logic             spi_rx_valid,
    input  logic             spi_ack_request,
    input  logic             spi_active
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        WDATA  = 3'd2,
        RDATA  = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_BURST);

    // Zero-length reads become single reads; oversized bursts are capped at the data block size.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] eff;
        if (len == LEN_ZERO) begin
            eff = LEN_ONE;
        end else if (len > LEN_MAX) begin
            eff = LEN_MAX;
        end else begin
            eff = len;
        end
        return eff;
    endfunction

    state_t           state_q, state_d;
    logic             write_q, write_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] req_left_q, req_left_d;
    logic [LEN_W-1:0] rx_left_q, rx_left_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_last_q, rd_last_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             tx_req_q, tx_req_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             rx_req_q, rx_req_d;

    logic             accept_s;
    logic [LEN_W-1:0] eff_len_s;

    // Next-state, request handshake and read-data path.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        len_d       = len_q;
        req_left_d  = req_left_q;
        rx_left_d   = rx_left_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        rd_last_d   = 1'b0;
        done_d      = 1'b0;
        busy_d      = busy_q;
        tx_req_d    = tx_req_q;
        tx_data_d   = tx_data_q;
        rx_req_d    = rx_req_q;
        accept_s    = (state_q == IDLE) && cmd_valid && cmd_ready_q;
        eff_len_s   = clamp_len(cmd_len);

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    write_d   = cmd_write;
                    wdata_d   = cmd_wdata;
                    len_d     = eff_len_s;
                    tx_req_d  = 1'b1;
                    tx_data_d = {~cmd_write, (~cmd_write && (eff_len_s > LEN_ONE)), cmd_addr};
                    rx_req_d  = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = CMD;
                end else begin
                    state_d = IDLE;
                end
            end
            CMD: begin
                if (spi_ack_request && write_q) begin
                    tx_data_d = wdata_q;
                    state_d   = WDATA;
                end else if (spi_ack_request) begin
                    tx_req_d   = 1'b0;
                    rx_req_d   = 1'b1;
                    req_left_d = len_q;
                    rx_left_d  = len_q;
                    state_d    = RDATA;
                end else begin
                    state_d = CMD;
                end
            end
            WDATA: begin
                if (spi_ack_request) begin
                    tx_req_d = 1'b0;
                    rx_req_d = 1'b0;
                    state_d  = FINISH;
                end else begin
                    state_d = WDATA;
                end
            end
            RDATA: begin
                if (spi_ack_request) begin
                    req_left_d = req_left_q - LEN_ONE;
                    if (req_left_q == LEN_ONE) begin
                        rx_req_d = 1'b0;
                        state_d  = FINISH;
                    end else begin
                        state_d = RDATA;
                    end
                end else begin
                    state_d = RDATA;
                end
            end
            FINISH: begin
                // Wait for the master to close chip-select and for every read byte to arrive.
                if (!spi_active && (rx_left_q == LEN_ZERO)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = FINISH;
                end
            end
            default: begin
                tx_req_d = 1'b0;
                rx_req_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
        endcase

        if (busy_q && !write_q && spi_rx_valid && (rx_left_q != LEN_ZERO)) begin
            rd_data_d  = spi_rx_data;
            rd_valid_d = 1'b1;
            rd_last_d  = (rx_left_q == LEN_ONE);
            rx_left_d  = rx_left_q - LEN_ONE;
        end else begin
            rd_valid_d = 1'b0;
        end

        cmd_ready_d = (state_d == IDLE) && !spi_active;
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            wdata_q     <= 8'h00;
            len_q       <= LEN_ZERO;
            req_left_q  <= LEN_ZERO;
            rx_left_q   <= LEN_ZERO;
            cmd_ready_q <= 1'b0;
            rd_data_q   <= 8'h00;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            tx_req_q    <= 1'b0;
            tx_data_q   <= 8'h00;
            rx_req_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            len_q       <= len_d;
            req_left_q  <= req_left_d;
            rx_left_q   <= rx_left_d;
            cmd_ready_q <= cmd_ready_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            tx_req_q    <= tx_req_d;
            tx_data_q   <= tx_data_d;
            rx_req_q    <= rx_req_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign rd_data        = rd_data_q;
    assign rd_valid       = rd_valid_q;
    assign rd_last        = rd_last_q;
    assign done           = done_q;
    assign busy           = busy_q;
    assign spi_tx_request = tx_req_q;
    assign spi_tx_data    = tx_data_q;
    assign spi_rx_request = rx_req_q;

endmodule

// File: tb/tb_spi_reg_access.sv
// Bench for spi_reg_access: byte-level SPI master model with an ADXL345 register model,
// a read-data scoreboard, and MOSI / chip-select window tracking.
module tb_spi_reg_access;

    localparam int LEN_W    = 3;
    localparam int BYTE_CYC = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [5:0]       cmd_addr;
    logic [7:0]       cmd_wdata;
    logic [LEN_W-1:0] cmd_len;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             rd_last;
    logic             done;
    logic             busy;
    logic             spi_tx_request;
    logic [7:0]       spi_tx_data;
    logic             spi_rx_request;
    logic [7:0]       spi_rx_data;
    logic             spi_rx_valid;
    logic             spi_ack_request;
    logic             spi_active;

    spi_reg_access #(.MAX_BURST(6)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .done(done), .busy(busy),
        .spi_tx_request(spi_tx_request), .spi_tx_data(spi_tx_data),
        .spi_rx_request(spi_rx_request), .spi_rx_data(spi_rx_data),
        .spi_rx_valid(spi_rx_valid), .spi_ack_request(spi_ack_request),
        .spi_active(spi_active)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] sb_q[$];
    logic [7:0] mosi_q[$];
    int         csn_cnt  = 0;
    int         rd_cnt   = 0;
    int         done_cnt = 0;
    logic [7:0] regs [0:63];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Byte-level master plus ADXL345 slave: each byte takes BYTE_CYC cycles, next request chained at byte end.
    initial begin : master
        int         m_cnt;
        logic       m_rx;
        logic [7:0] m_tx;
        logic [7:0] m_miso;
        logic       s_first;
        logic       s_rd;
        logic       s_mb;
        logic [5:0] s_addr;
        m_cnt = 0; m_rx = 1'b0; m_tx = 8'h00; m_miso = 8'h00;
        s_first = 1'b0; s_rd = 1'b0; s_mb = 1'b0; s_addr = 6'd0;
        spi_ack_request = 1'b0; spi_rx_valid = 1'b0; spi_active = 1'b0; spi_rx_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            spi_ack_request = 1'b0;
            spi_rx_valid    = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    mosi_q.push_back(m_tx);
                    if (s_first) begin
                        s_first = 1'b0;
                        s_rd    = m_tx[7];
                        s_mb    = m_tx[6];
                        s_addr  = m_tx[5:0];
                    end else if (!s_rd) begin
                        regs[s_addr] = m_tx;
                        s_addr = s_addr + {5'd0, s_mb};
                    end
                    if (m_rx) begin
                        spi_rx_valid = 1'b1;
                        spi_rx_data  = m_miso;
                    end
                    if (!(spi_tx_request || spi_rx_request)) spi_active = 1'b0;
                end
            end
            if (m_cnt == 0 && (spi_tx_request || spi_rx_request)) begin
                if (!spi_active) begin
                    csn_cnt++;
                    s_first    = 1'b1;
                    spi_active = 1'b1;
                end
                spi_ack_request = 1'b1;
                m_rx = spi_rx_request && !spi_tx_request;
                m_tx = spi_tx_request ? spi_tx_data : 8'h00;
                if (m_rx) begin
                    m_miso = regs[s_addr];
                    s_addr = s_addr + {5'd0, s_mb};
                end
                m_cnt = BYTE_CYC;
            end
        end
    end

    // Output monitor: pops the scoreboard on each read strobe.
    initial begin : monitor
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rd_valid) begin
                rd_cnt++;
                check_eq("rd_expected", (sb_q.size() != 0), 1'b1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check_eq("rd_data", rd_data, e[7:0]);
                    check_eq("rd_last", rd_last, e[8]);
                end
            end
            if (done) done_cnt++;
            if (cmd_valid && cmd_ready) check_eq("accept_idle", spi_active, 1'b0);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic push_exp(input int n, input logic [7:0] first);
        for (int i = 0; i < n; i++) begin
            sb_q.push_back({(i == n - 1), first + 8'(i)});
        end
    endtask

    task automatic issue_cmd(input logic w, input logic [5:0] a, input logic [7:0] wd, input logic [LEN_W-1:0] len);
        int n;
        n = 0;
        while (!cmd_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("ready_wait", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = wd; cmd_len = len;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check_eq("busy_after_accept", busy, 1'b1);
        check_eq("ready_after_accept", cmd_ready, 1'b0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("done_seen", done, 1'b1);
        check_eq("busy_at_done", busy, 1'b0);
    endtask

    task automatic do_cmd(input logic w, input logic [5:0] a, input logic [7:0] wd, input logic [LEN_W-1:0] len,
                          input logic [7:0] exp_cmd, input int exp_n, input logic [7:0] first);
        int csn0, rd0, done0;
        mosi_q.delete();
        csn0 = csn_cnt; rd0 = rd_cnt; done0 = done_cnt;
        push_exp(exp_n, first);
        issue_cmd(w, a, wd, len);
        wait_done();
        @(posedge clk); #1;
        check_eq("done_pulse", done, 1'b0);
        check_eq("mosi_count", mosi_q.size(), w ? 2 : exp_n + 1);
        if (mosi_q.size() >= 1) check_eq("mosi_cmd", mosi_q[0], exp_cmd);
        if (w && mosi_q.size() >= 2) check_eq("mosi_wdata", mosi_q[1], wd);
        check_eq("csn_windows", csn_cnt - csn0, 1);
        check_eq("rd_count", rd_cnt - rd0, exp_n);
        check_eq("done_count", done_cnt - done0, 1);
        check_eq("sb_drained", sb_q.size(), 0);
    endtask

    initial begin : stim
        int n, rd0, done0;
        for (int i = 0; i < 64; i++) regs[i] = 8'h00;
        regs[0] = 8'hE5;
        for (int i = 0; i < 6; i++) regs[6'h32 + i] = 8'h11 + 8'(i);
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 6'd0; cmd_wdata = 8'h00; cmd_len = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs",
                 {busy, cmd_ready, spi_tx_request, spi_rx_request, rd_valid, rd_last, done, spi_tx_data, rd_data},
                 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("ready_after_reset", cmd_ready, 1'b1);

        do_cmd(1'b1, 6'h2D, 8'h08, 3'd0, 8'h2D, 0, 8'h00);
        do_cmd(1'b0, 6'h00, 8'h00, 3'd1, 8'h80, 1, 8'hE5);
        do_cmd(1'b0, 6'h32, 8'h00, 3'd6, 8'hF2, 6, 8'h11);
        do_cmd(1'b0, 6'h32, 8'h00, 3'd0, 8'hB2, 1, 8'h11);
        do_cmd(1'b0, 6'h32, 8'h00, 3'd7, 8'hF2, 6, 8'h11);
        do_cmd(1'b0, 6'h33, 8'h00, 3'd2, 8'hF3, 2, 8'h12);
        do_cmd(1'b0, 6'h2D, 8'h00, 3'd1, 8'hAD, 1, 8'h08);

        // cmd_valid held through a whole command and its done pulse.
        mosi_q.delete();
        rd0 = rd_cnt; done0 = done_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h1E; cmd_wdata = 8'h5A; cmd_len = 3'd0;
        @(posedge clk); #1;
        check_eq("held_busy", busy, 1'b1);
        cmd_write = 1'b0; cmd_addr = 6'h00; cmd_len = 3'd1;
        push_exp(1, 8'hE5);
        wait_done();
        check_eq("held_first_mosi_n", mosi_q.size(), 2);
        if (mosi_q.size() >= 2) begin
            check_eq("held_first_cmd", mosi_q[0], 8'h1E);
            check_eq("held_first_wdata", mosi_q[1], 8'h5A);
        end
        check_eq("held_no_rd_first", rd_cnt - rd0, 0);
        check_eq("held_ready_at_done", cmd_ready, 1'b1);
        mosi_q.delete();
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check_eq("held_second_busy", busy, 1'b1);
        wait_done();
        check_eq("held_second_mosi_n", mosi_q.size(), 2);
        if (mosi_q.size() >= 1) check_eq("held_second_cmd", mosi_q[0], 8'h80);
        check_eq("held_rd_count", rd_cnt - rd0, 1);
        @(posedge clk); #1;
        check_eq("held_done_count", done_cnt - done0, 2);

        // Reset in the middle of a 6-byte burst.
        mosi_q.delete();
        rd0 = rd_cnt;
        push_exp(6, 8'h11);
        issue_cmd(1'b0, 6'h32, 8'h00, 3'd6);
        n = 0;
        while (rd_cnt < rd0 + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("mid_reads", rd_cnt - rd0, 2);
        #1 reset = 1'b1;
        #1;
        check_eq("midreset_outputs",
                 {busy, cmd_ready, spi_tx_request, spi_rx_request, rd_valid, rd_last, done, spi_tx_data, rd_data},
                 32'd0);
        sb_q.delete();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        n = 0;
        @(negedge clk);
        while (spi_active && n < 100) begin
            check_eq("ready_while_active", cmd_ready, 1'b0);
            @(negedge clk);
            n++;
        end
        check_eq("master_quiet", spi_active, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("no_rd_after_reset", rd_cnt - rd0, 2);
        do_cmd(1'b0, 6'h00, 8'h00, 3'd1, 8'h80, 1, 8'hE5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
